// File: rtl/mini_src_ctrl_pkg.sv
// Shared definitions for the Mini SRC control sequencer: state codes,
// opcode constants, opcode classification and the datapath strobe bundle.
package mini_src_ctrl_pkg;

  // State codes double as the externally visible step number.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd15
  } state_t;

  localparam logic [4:0] OP_LD   = 5'h00;
  localparam logic [4:0] OP_LDI  = 5'h01;
  localparam logic [4:0] OP_ST   = 5'h02;
  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_R_LO = 5'h03;
  localparam logic [4:0] OP_R_HI = 5'h0B;
  localparam logic [4:0] OP_I_LO = 5'h0C;
  localparam logic [4:0] OP_I_HI = 5'h0E;
  localparam logic [4:0] OP_MFHI = 5'h18;
  localparam logic [4:0] OP_MFLO = 5'h19;
  localparam logic [4:0] OP_NOP  = 5'h1A;
  localparam logic [4:0] OP_HALT = 5'h1B;

  localparam logic [4:0] ALU_ADD = 5'h03;

  // Execute-phase behaviour groups; nop, halt and undefined opcodes share CLS_NONE.
  typedef enum logic [2:0] {
    CLS_LD,
    CLS_LDI,
    CLS_ST,
    CLS_R,
    CLS_I,
    CLS_MFHI,
    CLS_MFLO,
    CLS_NONE
  } op_class_t;

  // Datapath strobes, named after the DataPath control inputs they drive.
  typedef struct packed {
    logic Pout;
    logic PCinc;
    logic MARen;
    logic MDRen;
    logic MDROut;
    logic IRen;
    logic Read;
    logic Write;
    logic Gra;
    logic Grb;
    logic Grc;
    logic Rin;
    logic Rout;
    logic BAout;
    logic Cout;
    logic Yen;
    logic ZLOen;
    logic ZLOout;
    logic HIout;
    logic LOout;
  } strobes_t;

  function automatic op_class_t op_class(input logic [4:0] op);
    if (op == OP_LD)                         return CLS_LD;
    else if (op == OP_LDI)                   return CLS_LDI;
    else if (op == OP_ST)                    return CLS_ST;
    else if (op >= OP_R_LO && op <= OP_R_HI) return CLS_R;
    else if (op >= OP_I_LO && op <= OP_I_HI) return CLS_I;
    else if (op == OP_MFHI)                  return CLS_MFHI;
    else if (op == OP_MFLO)                  return CLS_MFLO;
    else                                     return CLS_NONE;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decoder: maps (control step, opcode) to the datapath
// strobes and ALU select. Everything is zero in IDLE and HALT.
import mini_src_ctrl_pkg::*;

module ctrl_decode (
  input  state_t     state,
  input  logic [4:0] opcode,
  output strobes_t   strobes,
  output logic [4:0] alu_control
);

  op_class_t cls;
  assign cls = op_class(opcode);

  // Per-step strobe table; defaults keep unlisted steps/classes silent.
  always_comb begin
    strobes     = '0;
    alu_control = '0;
    case (state)
      ST_T0: begin
        strobes.Pout  = 1'b1;
        strobes.MARen = 1'b1;
        strobes.PCinc = 1'b1;
      end
      ST_T1: begin
        strobes.Read  = 1'b1;
        strobes.MDRen = 1'b1;
      end
      ST_T2: begin
        strobes.MDROut = 1'b1;
        strobes.IRen   = 1'b1;
      end
      ST_T3: begin
        case (cls)
          CLS_R, CLS_I: begin
            strobes.Grb  = 1'b1;
            strobes.Rout = 1'b1;
            strobes.Yen  = 1'b1;
          end
          CLS_LDI, CLS_LD, CLS_ST: begin
            strobes.Grb   = 1'b1;
            strobes.BAout = 1'b1;
            strobes.Yen   = 1'b1;
          end
          CLS_MFHI: begin
            strobes.Gra   = 1'b1;
            strobes.Rin   = 1'b1;
            strobes.HIout = 1'b1;
          end
          CLS_MFLO: begin
            strobes.Gra   = 1'b1;
            strobes.Rin   = 1'b1;
            strobes.LOout = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        case (cls)
          CLS_R: begin
            strobes.Grc   = 1'b1;
            strobes.Rout  = 1'b1;
            strobes.ZLOen = 1'b1;
            alu_control   = opcode;
          end
          CLS_I: begin
            strobes.Cout  = 1'b1;
            strobes.ZLOen = 1'b1;
            alu_control   = opcode;
          end
          // Address / immediate forming always adds base + constant.
          CLS_LDI, CLS_LD, CLS_ST: begin
            strobes.Cout  = 1'b1;
            strobes.ZLOen = 1'b1;
            alu_control   = ALU_ADD;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (cls)
          CLS_R, CLS_I, CLS_LDI: begin
            strobes.ZLOout = 1'b1;
            strobes.Gra    = 1'b1;
            strobes.Rin    = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            strobes.ZLOout = 1'b1;
            strobes.MARen  = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        case (cls)
          CLS_LD: begin
            strobes.Read  = 1'b1;
            strobes.MDRen = 1'b1;
          end
          CLS_ST: begin
            strobes.Gra   = 1'b1;
            strobes.Rout  = 1'b1;
            strobes.MDRen = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T7: begin
        case (cls)
          CLS_LD: begin
            strobes.MDROut = 1'b1;
            strobes.Gra    = 1'b1;
            strobes.Rin    = 1'b1;
          end
          CLS_ST: strobes.Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Mini SRC hardwired control sequencer: fetch (T0-T2) with memory wait
// states, opcode-dependent execute (T3-T7), run/halt control and a sticky
// memory-timeout fault. Optional macro SINGLE_STEP_EN adds a step_req input
// that launches exactly one instruction from IDLE.
import mini_src_ctrl_pkg::*;

module ctrl_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
`ifdef SINGLE_STEP_EN
  input  logic        step_req,
`endif
  input  logic [31:0] ir,
  input  logic        mem_rdy,
  output logic        Pout,
  output logic        PCinc,
  output logic        MARen,
  output logic        MDRen,
  output logic        MDROut,
  output logic        IRen,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        Yen,
  output logic        ZLOen,
  output logic        ZLOout,
  output logic        HIout,
  output logic        LOout,
  output logic [4:0]  alu_control,
  output logic [3:0]  step,
  output logic        halted,
  output logic        mem_err
);

  localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic [TO_W-1:0] wait_cnt;
  logic [4:0]      opcode;
  op_class_t       cls;
  strobes_t        strobes;
  logic            start_req;
  logic            in_wait;
  logic            wait_expired;
  state_t          end_state;
  logic            unused_ir;

  assign opcode    = ir[31:27];
  assign cls       = op_class(opcode);
  assign unused_ir = ^ir[26:0];

`ifdef SINGLE_STEP_EN
  assign start_req = run | step_req;
`else
  assign start_req = run;
`endif

  // Memory wait steps: fetch read, ld operand read, st write.
  assign in_wait      = (state == ST_T1) ||
                        (state == ST_T6 && cls == CLS_LD) ||
                        (state == ST_T7 && cls == CLS_ST);
  // A ready in the final allowed cycle still counts as success.
  assign wait_expired = in_wait && !mem_rdy && (wait_cnt == WAIT_LAST);
  // Instructions always complete; run only decides whether another follows.
  assign end_state    = run ? ST_T0 : ST_IDLE;

  // Wait counter: zero outside wait steps, so every wait step starts from 0.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wait_cnt <= '0;
    end else if (!in_wait || mem_rdy) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + TO_W'(1);
    end
  end

  // Control-step FSM with registered halted / mem_err status.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= ST_IDLE;
      halted  <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start_req) state <= ST_T0;
        ST_T0:   state <= ST_T1;
        ST_T1: begin
          if (mem_rdy) begin
            state <= ST_T2;
          end else if (wait_expired) begin
            state   <= ST_HALT;
            halted  <= 1'b1;
            mem_err <= 1'b1;
          end
        end
        ST_T2:   state <= ST_T3;
        ST_T3: begin
          if (opcode == OP_HALT) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (cls inside {CLS_R, CLS_I, CLS_LDI, CLS_LD, CLS_ST}) begin
            state <= ST_T4;
          end else begin
            state <= end_state;
          end
        end
        ST_T4:   state <= ST_T5;
        ST_T5:   state <= (cls == CLS_LD || cls == CLS_ST) ? ST_T6 : end_state;
        ST_T6: begin
          if (cls == CLS_LD) begin
            if (mem_rdy) begin
              state <= ST_T7;
            end else if (wait_expired) begin
              state   <= ST_HALT;
              halted  <= 1'b1;
              mem_err <= 1'b1;
            end
          end else if (cls == CLS_ST) begin
            state <= ST_T7;
          end else begin
            state <= end_state;
          end
        end
        ST_T7: begin
          if (cls == CLS_ST) begin
            if (mem_rdy) begin
              state <= end_state;
            end else if (wait_expired) begin
              state   <= ST_HALT;
              halted  <= 1'b1;
              mem_err <= 1'b1;
            end
          end else begin
            state <= end_state;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  ctrl_decode u_decode (
    .state       (state),
    .opcode      (opcode),
    .strobes     (strobes),
    .alu_control (alu_control)
  );

  assign step   = state;
  assign Pout   = strobes.Pout;
  assign PCinc  = strobes.PCinc;
  assign MARen  = strobes.MARen;
  assign MDRen  = strobes.MDRen;
  assign MDROut = strobes.MDROut;
  assign IRen   = strobes.IRen;
  assign Read   = strobes.Read;
  assign Write  = strobes.Write;
  assign Gra    = strobes.Gra;
  assign Grb    = strobes.Grb;
  assign Grc    = strobes.Grc;
  assign Rin    = strobes.Rin;
  assign Rout   = strobes.Rout;
  assign BAout  = strobes.BAout;
  assign Cout   = strobes.Cout;
  assign Yen    = strobes.Yen;
  assign ZLOen  = strobes.ZLOen;
  assign ZLOout = strobes.ZLOout;
  assign HIout  = strobes.HIout;
  assign LOout  = strobes.LOout;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: per-cycle step/strobe/ALU checks for
// mflo, R-class add with fetch wait states, st with write wait states,
// wait-state timeout (and its ready-wins boundary), halt, async clear,
// run drop mid-instruction and, when SINGLE_STEP_EN is defined, single step.
module tb_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        run;
  logic [31:0] ir;
  logic        mem_rdy;
`ifdef SINGLE_STEP_EN
  logic        step_req;
`endif
  logic Pout, PCinc, MARen, MDRen, MDROut, IRen, Read, Write;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, Yen, ZLOen, ZLOout, HIout, LOout;
  logic [4:0] alu_control;
  logic [3:0] step;
  logic       halted;
  logic       mem_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ctrl_sequencer #(.TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .clr(clr), .run(run),
`ifdef SINGLE_STEP_EN
    .step_req(step_req),
`endif
    .ir(ir), .mem_rdy(mem_rdy),
    .Pout(Pout), .PCinc(PCinc), .MARen(MARen), .MDRen(MDRen), .MDROut(MDROut),
    .IRen(IRen), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout), .Yen(Yen), .ZLOen(ZLOen),
    .ZLOout(ZLOout), .HIout(HIout), .LOout(LOout), .alu_control(alu_control),
    .step(step), .halted(halted), .mem_err(mem_err)
  );

  wire [19:0] str = {Pout, PCinc, MARen, MDRen, MDROut, IRen, Read, Write,
                     Gra, Grb, Grc, Rin, Rout, BAout, Cout, Yen, ZLOen, ZLOout,
                     HIout, LOout};

  localparam logic [19:0] S_POUT   = 20'h80000;
  localparam logic [19:0] S_PCINC  = 20'h40000;
  localparam logic [19:0] S_MAREN  = 20'h20000;
  localparam logic [19:0] S_MDREN  = 20'h10000;
  localparam logic [19:0] S_MDROUT = 20'h08000;
  localparam logic [19:0] S_IREN   = 20'h04000;
  localparam logic [19:0] S_READ   = 20'h02000;
  localparam logic [19:0] S_WRITE  = 20'h01000;
  localparam logic [19:0] S_GRA    = 20'h00800;
  localparam logic [19:0] S_GRB    = 20'h00400;
  localparam logic [19:0] S_GRC    = 20'h00200;
  localparam logic [19:0] S_RIN    = 20'h00100;
  localparam logic [19:0] S_ROUT   = 20'h00080;
  localparam logic [19:0] S_BAOUT  = 20'h00040;
  localparam logic [19:0] S_COUT   = 20'h00020;
  localparam logic [19:0] S_YEN    = 20'h00010;
  localparam logic [19:0] S_ZLOEN  = 20'h00008;
  localparam logic [19:0] S_ZLOOUT = 20'h00004;
  localparam logic [19:0] S_HIOUT  = 20'h00002;
  localparam logic [19:0] S_LOOUT  = 20'h00001;

  localparam logic [19:0] F_T0 = S_POUT | S_MAREN | S_PCINC;
  localparam logic [19:0] F_T1 = S_READ | S_MDREN;
  localparam logic [19:0] F_T2 = S_MDROUT | S_IREN;

  localparam logic [31:0] IR_MFLO = 32'hC880_0000;  // opcode 19h, ra=R1
  localparam logic [31:0] IR_ADD  = 32'h1891_8000;  // opcode 03h, R1,R2,R3
  localparam logic [31:0] IR_ST   = 32'h1000_0000;  // opcode 02h
  localparam logic [31:0] IR_NOP  = 32'hD000_0000;  // opcode 1Ah
  localparam logic [31:0] IR_HALT = 32'hD800_0000;  // opcode 1Bh

  // Clear, load inputs, then release; the next negedge observes the first step.
  task automatic restart(input logic [31:0] ir_v, input logic run_v, input logic rdy_v);
    @(negedge clk);
    clr = 1'b1; ir = ir_v; run = run_v; mem_rdy = rdy_v;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset;
    clr = 1'b1; run = 1'b0; ir = '0; mem_rdy = 1'b0;
`ifdef SINGLE_STEP_EN
    step_req = 1'b0;
`endif
    @(negedge clk);
    n_tests++;
    if ({step, halted, mem_err, str, alu_control} !== '0) begin
      n_fail++;
      $display("FAIL reset: got step=%0d halted=%b mem_err=%b str=%h alu=%h, want all 0",
               step, halted, mem_err, str, alu_control);
    end
  endtask

  task automatic test_mflo;
    logic [3:0] es; logic [19:0] ef;
    restart(IR_MFLO, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      case (i)
        0: begin es = 4'd1; ef = F_T0; end
        1: begin es = 4'd2; ef = F_T1; end
        2: begin es = 4'd3; ef = F_T2; end
        3: begin es = 4'd4; ef = S_GRA | S_RIN | S_LOOUT; end
        default: begin es = 4'd1; ef = F_T0; end
      endcase
      n_tests++;
      if ({step, str, alu_control} !== {es, ef, 5'h00}) begin
        n_fail++;
        $display("FAIL mflo c%0d: got step=%0d str=%h alu=%h, want step=%0d str=%h alu=00",
                 i, step, str, alu_control, es, ef);
      end
    end
  endtask

  task automatic test_rclass;
    logic [3:0] es; logic [19:0] ef; logic [4:0] ea;
    restart(IR_ADD, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ea = 5'h00;
      case (i)
        0:          begin es = 4'd1; ef = F_T0; end
        1, 2, 3, 4: begin es = 4'd2; ef = F_T1; end
        5:          begin es = 4'd3; ef = F_T2; end
        6:          begin es = 4'd4; ef = S_GRB | S_ROUT | S_YEN; end
        7:          begin es = 4'd5; ef = S_GRC | S_ROUT | S_ZLOEN; ea = 5'h03; end
        8:          begin es = 4'd6; ef = S_ZLOOUT | S_GRA | S_RIN; end
        default:    begin es = 4'd1; ef = F_T0; end
      endcase
      n_tests++;
      if ({step, str, alu_control} !== {es, ef, ea}) begin
        n_fail++;
        $display("FAIL rclass c%0d: got step=%0d str=%h alu=%h, want step=%0d str=%h alu=%h",
                 i, step, str, alu_control, es, ef, ea);
      end
      mem_rdy = (i >= 4);
    end
  endtask

  task automatic test_store;
    logic [3:0] es; logic [19:0] ef; logic [4:0] ea;
    restart(IR_ST, 1'b1, 1'b1);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      ea = 5'h00;
      case (i)
        0:       begin es = 4'd1; ef = F_T0; end
        1:       begin es = 4'd2; ef = F_T1; end
        2:       begin es = 4'd3; ef = F_T2; end
        3:       begin es = 4'd4; ef = S_GRB | S_BAOUT | S_YEN; end
        4:       begin es = 4'd5; ef = S_COUT | S_ZLOEN; ea = 5'h03; end
        5:       begin es = 4'd6; ef = S_ZLOOUT | S_MAREN; end
        6:       begin es = 4'd7; ef = S_GRA | S_ROUT | S_MDREN; end
        7, 8, 9: begin es = 4'd8; ef = S_WRITE; end
        default: begin es = 4'd1; ef = F_T0; end
      endcase
      n_tests++;
      if ({step, str, alu_control} !== {es, ef, ea}) begin
        n_fail++;
        $display("FAIL store c%0d: got step=%0d str=%h alu=%h, want step=%0d str=%h alu=%h",
                 i, step, str, alu_control, es, ef, ea);
      end
      mem_rdy = !(i >= 6 && i <= 8);
    end
    n_tests++;
    if (mem_err !== 1'b0) begin
      n_fail++;
      $display("FAIL store_mem_err: got %b, want 0", mem_err);
    end
  endtask

  task automatic test_timeout;
    logic [3:0] es;
    restart(IR_NOP, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      es = (i == 0) ? 4'd1 : (i <= 16) ? 4'd2 : 4'd15;
      n_tests++;
      if (step !== es) begin
        n_fail++;
        $display("FAIL timeout_step c%0d: got %0d, want %0d", i, step, es);
      end
    end
    n_tests++;
    if ({halted, mem_err, str, alu_control} !== {1'b1, 1'b1, 20'h0, 5'h00}) begin
      n_fail++;
      $display("FAIL timeout_flags: got halted=%b mem_err=%b str=%h alu=%h, want 1 1 00000 00",
               halted, mem_err, str, alu_control);
    end
    @(negedge clk);
    n_tests++;
    if ({step, mem_err} !== {4'd15, 1'b1}) begin
      n_fail++;
      $display("FAIL timeout_hold: got step=%0d mem_err=%b, want 15 1", step, mem_err);
    end
    clr = 1'b1;
    #1;
    n_tests++;
    if ({step, mem_err, halted} !== {4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_clr: got step=%0d mem_err=%b halted=%b, want 0 0 0",
               step, mem_err, halted);
    end
    // Ready arriving in the last allowed wait cycle must still advance.
    restart(IR_NOP, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      es = (i == 0) ? 4'd1 : (i <= 16) ? 4'd2 : 4'd3;
      n_tests++;
      if (step !== es) begin
        n_fail++;
        $display("FAIL timeout_edge c%0d: got %0d, want %0d", i, step, es);
      end
      mem_rdy = (i == 16);
    end
    n_tests++;
    if ({mem_err, halted} !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_edge_flags: got mem_err=%b halted=%b, want 0 0", mem_err, halted);
    end
  endtask

  task automatic test_halt;
    logic [3:0] es; logic [19:0] ef; logic eh;
    restart(IR_HALT, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      eh = 1'b0;
      case (i)
        0:       begin es = 4'd1; ef = F_T0; end
        1:       begin es = 4'd2; ef = F_T1; end
        2:       begin es = 4'd3; ef = F_T2; end
        3:       begin es = 4'd4; ef = 20'h0; end
        default: begin es = 4'd15; ef = 20'h0; eh = 1'b1; end
      endcase
      n_tests++;
      if ({step, str, halted, mem_err} !== {es, ef, eh, 1'b0}) begin
        n_fail++;
        $display("FAIL halt c%0d: got step=%0d str=%h halted=%b mem_err=%b, want step=%0d str=%h halted=%b mem_err=0",
                 i, step, str, halted, mem_err, es, ef, eh);
      end
    end
    // Asynchronous clear in the middle of T5 of a later instruction.
    restart(IR_ADD, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_tests++;
      if (step !== 4'(i + 1)) begin
        n_fail++;
        $display("FAIL clr_pre c%0d: got %0d, want %0d", i, step, i + 1);
      end
    end
    #2 clr = 1'b1;
    #1;
    n_tests++;
    if ({step, str, alu_control, halted} !== '0) begin
      n_fail++;
      $display("FAIL clr_mid: got step=%0d str=%h alu=%h halted=%b, want all 0",
               step, str, alu_control, halted);
    end
  endtask

  task automatic test_run_drop;
    logic [3:0] es;
    restart(IR_ADD, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      es = (i <= 5) ? 4'(i + 1) : 4'd0;
      n_tests++;
      if (step !== es) begin
        n_fail++;
        $display("FAIL run_drop c%0d: got %0d, want %0d", i, step, es);
      end
      run = 1'b0;
    end
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_single_step;
    logic [3:0] es;
    step_req = 1'b0;
    restart(IR_NOP, 1'b0, 1'b1);
    @(negedge clk);
    n_tests++;
    if (step !== 4'd0) begin
      n_fail++;
      $display("FAIL sstep_idle: got %0d, want 0", step);
    end
    step_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      es = (i <= 3) ? 4'(i + 1) : 4'd0;
      n_tests++;
      if (step !== es) begin
        n_fail++;
        $display("FAIL sstep c%0d: got %0d, want %0d", i, step, es);
      end
      step_req = (i == 2);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mflo();
    test_rclass();
    test_store();
    test_timeout();
    test_halt();
    test_run_drop();
`ifdef SINGLE_STEP_EN
    test_single_step();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
